// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// muldiv_pkg : shared op codes, FSM states and special-result constants
// Rev 1.0
// ============================================================================
package muldiv_pkg;

    localparam int XLEN = 32;

    // RV32M funct3 encodings
    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

endpackage
`default_nettype wire

// File: rtl/divu_iter.sv
`default_nettype none
// ============================================================================
// divu_iter : unsigned restoring divider, one quotient bit per enabled cycle
// Rev 1.0
// ============================================================================
module divu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_load,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_quo_nxt,
    output logic [WIDTH-1:0] o_rem_nxt
);

    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;
    logic             w_ge;

    // The dividend shifts out of r_quo's top while quotient bits shift in below.
    assign w_shift   = {r_rem, r_quo[WIDTH-1]};
    assign w_diff    = w_shift - {1'b0, r_dvs};
    assign w_ge      = ~w_diff[WIDTH];
    assign o_rem_nxt = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign o_quo_nxt = {r_quo[WIDTH-2:0], w_ge};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rem <= '0;
            r_quo <= '0;
            r_dvs <= '0;
        end else if (i_load) begin
            r_rem <= '0;
            r_quo <= i_dividend;
            r_dvs <= i_divisor;
        end else if (i_en) begin
            r_rem <= o_rem_nxt;
            r_quo <= o_quo_nxt;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ex_muldiv.sv
`default_nettype none
// ============================================================================
// ex_muldiv : iterative RV32M multiply/divide unit for the EX stage.
// Define MULDIV_FAST_MUL_EN for single-cycle multiplies.          Rev 1.0
// ============================================================================
module ex_muldiv
    import muldiv_pkg::*;
#(
    parameter int WIDTH = XLEN
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH);

    state_t             r_state;
    logic [CW-1:0]      r_cnt;
    logic [2:0]         r_op;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_done;
    logic [WIDTH-1:0]   r_result;
    logic [WIDTH-1:0]   r_mcand;
    logic [2*WIDTH-1:0] r_prod;

    logic               w_accept;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic               w_div0;
    logic               w_ovf;
    logic               w_special;
    logic [WIDTH-1:0]   w_special_res;
    logic               w_fast;
    logic [WIDTH-1:0]   w_fast_res;
    logic [WIDTH:0]     w_add;
    logic [2*WIDTH-1:0] w_prod_nxt;
    logic [WIDTH-1:0]   w_quo_nxt;
    logic [WIDTH-1:0]   w_rem_nxt;

    // Apply the deferred sign and pick the half / quotient / remainder for an op.
    function automatic logic [WIDTH-1:0] f_fix(
        input logic [2:0]       fop,
        input logic             neg_q,
        input logic             neg_r,
        input logic [2*WIDTH-1:0] prod,
        input logic [WIDTH-1:0] quo,
        input logic [WIDTH-1:0] rem
    );
        logic [2*WIDTH-1:0] p;
        logic [WIDTH-1:0]   q;
        logic [WIDTH-1:0]   r;
        logic [WIDTH-1:0]   res;
        p = neg_q ? -prod : prod;
        q = neg_q ? -quo : quo;
        r = neg_r ? -rem : rem;
        if (!fop[2])
            res = (fop == OP_MUL) ? p[WIDTH-1:0] : p[2*WIDTH-1:WIDTH];
        else
            res = fop[1] ? r : q;
        return res;
    endfunction

    assign w_accept = (r_state == ST_IDLE) && start && !flush;
    assign w_a_neg  = a[WIDTH-1] && (op == OP_MULH || op == OP_MULHSU || op == OP_DIV || op == OP_REM);
    assign w_b_neg  = b[WIDTH-1] && (op == OP_MULH || op == OP_DIV || op == OP_REM);
    assign w_a_mag  = w_a_neg ? -a : a;
    assign w_b_mag  = w_b_neg ? -b : b;

    assign w_div0    = op[2] && (b == '0);
    assign w_ovf     = (op == OP_DIV || op == OP_REM) && (a == WIDTH'(INT_MIN)) && (b == WIDTH'(ALL_ONES));
    assign w_special = w_div0 || w_ovf;

    always_comb begin
        w_special_res = '0;
        if (w_div0)
            w_special_res = op[1] ? a : WIDTH'(ALL_ONES);
        else if (!op[1])
            w_special_res = WIDTH'(INT_MIN);
    end

`ifdef MULDIV_FAST_MUL_EN
    assign w_fast     = !op[2];
    assign w_fast_res = f_fix(op, w_a_neg ^ w_b_neg, 1'b0,
                              {{WIDTH{1'b0}}, w_a_mag} * {{WIDTH{1'b0}}, w_b_mag}, '0, '0);
`else
    assign w_fast     = 1'b0;
    assign w_fast_res = '0;
`endif

    // Shift-add multiply: multiplier sits in the low half and is consumed LSB first.
    assign w_add      = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_mcand} : '0);
    assign w_prod_nxt = {w_add, r_prod[WIDTH-1:1]};

    divu_iter #(
        .WIDTH (WIDTH)
    ) u_divu_iter (
        .clk        (clk),
        .rstn       (rstn),
        .i_load     (w_accept),
        .i_en       ((r_state == ST_CALC) && r_op[2]),
        .i_dividend (w_a_mag),
        .i_divisor  (w_b_mag),
        .o_quo_nxt  (w_quo_nxt),
        .o_rem_nxt  (w_rem_nxt)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_op     <= OP_MUL;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_mcand  <= '0;
            r_prod   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (w_accept) begin
                        r_op    <= op;
                        r_neg_q <= w_a_neg ^ w_b_neg;
                        r_neg_r <= w_a_neg;
                        r_mcand <= w_a_mag;
                        r_prod  <= {{WIDTH{1'b0}}, w_b_mag};
                        r_cnt   <= '0;
                        if (w_special) begin
                            r_result <= w_special_res;
                            r_done   <= 1'b1;
                            r_state  <= ST_FIN;
                        end else if (w_fast) begin
                            r_result <= w_fast_res;
                            r_done   <= 1'b1;
                            r_state  <= ST_FIN;
                        end else begin
                            r_state <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    if (!r_op[2])
                        r_prod <= w_prod_nxt;
                    if (flush) begin
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                    end else if (r_cnt == CW'(WIDTH-1)) begin
                        // Last step's next-values feed the result so done lands in FIN.
                        r_result <= f_fix(r_op, r_neg_q, r_neg_r, w_prod_nxt, w_quo_nxt, w_rem_nxt);
                        r_done   <= 1'b1;
                        r_cnt    <= '0;
                        r_state  <= ST_FIN;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_FIN: begin
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign stall  = w_accept || (r_state == ST_CALC);
    assign done   = r_done;
    assign result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv.sv
`default_nettype none
// ============================================================================
// tb_ex_muldiv : directed and randomized checks of ex_muldiv against a
// cycle-count reference model.                                   Rev 1.0
// ============================================================================
module tb_ex_muldiv;
    import muldiv_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif

    logic        clk   = 1'b0;
    logic        rstn  = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  op    = 3'b000;
    logic [31:0] a     = '0;
    logic [31:0] b     = '0;
    logic        stall;
    logic        done;
    logic [31:0] result;

    int total = 0;
    int bad   = 0;
    int n_stall;

    ex_muldiv #(.WIDTH(32)) dut (
        .clk    (clk),
        .rstn   (rstn),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .flush  (flush),
        .stall  (stall),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_res(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint          sx = longint'($signed(x));
        longint          sy = longint'($signed(y));
        longint unsigned ux = 64'(x);
        longint unsigned uy = 64'(y);
        logic [63:0]     p;
        logic [31:0]     r;
        logic            ovf;
        ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
        r = '0;
        case (o)
            OP_MUL:    begin p = ux * uy; r = p[31:0];  end
            OP_MULH:   begin p = sx * sy; r = p[63:32]; end
            OP_MULHSU: begin p = sx * uy; r = p[63:32]; end
            OP_MULHU:  begin p = ux * uy; r = p[63:32]; end
            OP_DIV:    r = (y == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sx / sy);
            OP_DIVU:   r = (y == 0) ? 32'hFFFF_FFFF : x / y;
            OP_REM:    r = (y == 0) ? x : ovf ? 32'h0 : 32'(sx % sy);
            default:   r = (y == 0) ? x : x % y;
        endcase
        return r;
    endfunction

    function automatic int ref_lat(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        if (!o[2]) return MUL_LAT;
        if (y == 0) return 1;
        if ((o == OP_DIV || o == OP_REM) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Model: cycles left until the done cycle, plus the result that will appear then.
    int          m_left = 0;
    bit          m_done = 0;
    logic [31:0] m_res  = '0;
    logic [31:0] m_pend = '0;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_left = 0;
            m_done = 0;
            m_res  = '0;
        end else if (m_done) begin
            m_done = 0;
        end else if (m_left > 0) begin
            if (flush) begin
                m_left = 0;
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_done = 1;
                    m_res  = m_pend;
                end
            end
        end else if (start && !flush) begin
            m_pend = ref_res(op, a, b);
            m_left = ref_lat(op, a, b) - 1;
            if (m_left == 0) begin
                m_done = 1;
                m_res  = m_pend;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic issue(input bit wait_first, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        if (wait_first) begin
            @(posedge clk);
            #1;
        end
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        #1;
        n_stall = stall ? 1 : 0;
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = 3'($urandom);
        a     = $urandom;
        b     = $urandom;
    endtask

    task automatic wait_done(input string name, input logic [31:0] exp, input int exp_lat);
        int lat = 1;
        while (!done && lat < 40) begin
            if (stall) n_stall++;
            @(posedge clk);
            #1;
            lat++;
        end
        check({name, " result"}, result, exp);
        check({name, " latency"}, 32'(lat), 32'(exp_lat));
        check({name, " stall cycles"}, 32'(n_stall), 32'(exp_lat));
        check({name, " stall at done"}, 32'(stall), 32'd0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;

        fork
            forever begin
                @(negedge clk);
                check("cyc stall",  32'(stall), 32'(((m_left == 0) && !m_done && start && !flush) || (m_left > 0)));
                check("cyc done",   32'(done), 32'(m_done));
                check("cyc result", result, m_res);
            end
        join_none

        // Model pinned to hand-computed values
        check("model div",    ref_res(OP_DIV,    32'hFFFF_FF9C, 32'd7), 32'hFFFF_FFF2);
        check("model rem",    ref_res(OP_REM,    32'hFFFF_FF9C, 32'd7), 32'hFFFF_FFFE);
        check("model mulh",   ref_res(OP_MULH,   32'h8000_0000, 32'h8000_0000), 32'h4000_0000);
        check("model mulhsu", ref_res(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFF);

        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        #1;
        check("reset result", result, 32'h0);
        check("reset done",   32'(done), 32'd0);
        check("reset stall",  32'(stall), 32'd0);

        // Reset in the middle of a divide discards it
        issue(1, OP_DIV, 32'd100, 32'd7);
        check("t1 stall calc", 32'(stall), 32'd1);
        repeat (4) @(posedge clk);
        #1 rstn = 1'b0;
        #1;
        check("t1 stall in reset", 32'(stall), 32'd0);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        pulses = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        check("t1 done pulses", 32'(pulses), 32'd0);
        check("t1 result", result, 32'h0);

        issue(1, OP_DIV,    32'hFFFF_FF9C, 32'd7);          wait_done("div -100/7",  32'hFFFF_FFF2, 33);
        issue(1, OP_REM,    32'hFFFF_FF9C, 32'd7);          wait_done("rem -100/7",  32'hFFFF_FFFE, 33);
        issue(1, OP_DIVU,   32'd5, 32'd0);                  wait_done("divu 5/0",    32'hFFFF_FFFF, 1);
        issue(1, OP_REMU,   32'd5, 32'd0);                  wait_done("remu 5/0",    32'd5, 1);
        issue(1, OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF);  wait_done("div ovf",     32'h8000_0000, 1);
        issue(1, OP_REM,    32'h8000_0000, 32'hFFFF_FFFF);  wait_done("rem ovf",     32'h0, 1);
        issue(1, OP_MUL,    32'd7, 32'hFFFF_FFFD);          wait_done("mul 7*-3",    32'hFFFF_FFEB, MUL_LAT);
        issue(1, OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF);  wait_done("mulhu",       32'hFFFF_FFFE, MUL_LAT);
        issue(1, OP_MULH,   32'h8000_0000, 32'h8000_0000);  wait_done("mulh",        32'h4000_0000, MUL_LAT);
        issue(1, OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);  wait_done("mulhsu",      32'hFFFF_FFFF, MUL_LAT);

        // Flush mid-divide, then an immediate restart
        issue(1, OP_DIVU, 32'd1000, 32'd3);
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        check("t6 stall after flush", 32'(stall), 32'd0);
        check("t6 done after flush",  32'(done), 32'd0);
        check("t6 result kept",       result, 32'hFFFF_FFFF);
        issue(0, OP_DIVU, 32'd9, 32'd2);
        wait_done("divu 9/2", 32'd4, 33);

        // start together with flush in IDLE is not accepted
        @(posedge clk);
        #1;
        start = 1'b1;
        flush = 1'b1;
        op    = OP_DIVU;
        a     = 32'd50;
        b     = 32'd5;
        #1;
        check("flush+start stall", 32'(stall), 32'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        #1;
        check("flush+start idle", 32'(stall), 32'd0);

        // Randomized traffic with stray starts, operand churn and occasional flushes
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk);
            #1;
            start = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 39) == 0);
            op    = 3'($urandom);
            a     = pick();
            b     = pick();
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        repeat (40) @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
